// File: rtl/bfp2fix_stream.sv
// Block-floating-point stream decoder: one shared-exponent header word, then BLOCK_LEN mantissas,
// each expanded to unsigned fixed point as mantissa << exponent.
module bfp2fix_stream #(
    parameter int MAN_WIDTH = 5,
    parameter int EXP_WIDTH = 3,
    parameter int BLOCK_LEN = 4,
    localparam int FIX_WIDTH = MAN_WIDTH + 2**EXP_WIDTH - 1,
    localparam int CNT_WIDTH = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MAN_WIDTH-1:0] inp_data,
    input  logic                 inp_valid,
    output logic                 inp_ready,
    output logic [FIX_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic                 busy
);

    typedef enum logic {HEADER, DATA} state_t;

    state_t                 state, state_next;
    logic [CNT_WIDTH-1:0]   cnt, cnt_next;
    logic [EXP_WIDTH-1:0]   exp_reg, exp_next;
    logic                   load_out;
    logic                   last_word;

    assign last_word = (cnt == CNT_WIDTH'(BLOCK_LEN - 1));
    assign busy      = (state == DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HEADER;
            cnt     <= '0;
            exp_reg <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            exp_reg <= exp_next;
        end
    end

    // In DATA a mantissa is only taken when the output slot is free or being emptied this cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        exp_next   = exp_reg;
        inp_ready  = 1'b1;
        load_out   = 1'b0;
        case (state)
            HEADER: begin
                inp_ready = 1'b1;
                if (inp_valid) begin
                    exp_next   = inp_data[EXP_WIDTH-1:0];
                    cnt_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                inp_ready = ~out_valid | out_ready;
                if (inp_valid && inp_ready) begin
                    load_out = 1'b1;
                    if (last_word) begin
                        cnt_next   = '0;
                        state_next = HEADER;
                    end else begin
                        cnt_next = cnt + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_next = HEADER;
            end
        endcase
    end

    // A new sample overwrites a sample leaving in the same cycle, so throughput has no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            out_data  <= FIX_WIDTH'(inp_data) << exp_reg;
            out_sop   <= (cnt == '0);
            out_eop   <= last_word;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bfp2fix_stream.sv
// Self-checking bench for bfp2fix_stream: directed block scenarios plus randomized handshakes,
// all compared against a queue-based model of the block format.
module tb_bfp2fix_stream;

    localparam int MAN_W = 5;
    localparam int EXP_W = 3;
    localparam int BLK   = 4;
    localparam int FIX_W = MAN_W + 2**EXP_W - 1;

    typedef struct {
        int data;
        bit sop;
        bit eop;
    } sample_t;

    logic             clk;
    logic             rst;
    logic [MAN_W-1:0] inp_data;
    logic             inp_valid;
    logic             inp_ready;
    logic [FIX_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sop;
    logic             out_eop;
    logic             busy;

    int      checks   = 0;
    int      failures = 0;
    bit      mon_en   = 0;
    bit      rand_mode = 0;
    sample_t exp_q[$];
    sample_t got[$];
    bit      m_hdr = 1;
    int      m_idx = 0;
    int      m_exp = 0;

    bfp2fix_stream #(
        .MAN_WIDTH(MAN_W),
        .EXP_WIDTH(EXP_W),
        .BLOCK_LEN(BLK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inp_data (inp_data),
        .inp_valid(inp_valid),
        .inp_ready(inp_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sop  (out_sop),
        .out_eop  (out_eop),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Reference: headers set the exponent, each mantissa is queued as value*2^exp with its
    // position in the block; the DUT's single output slot must always show the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                exp_q.delete();
                m_hdr = 1;
                m_idx = 0;
            end else begin
                checkOutput("inp_ready", int'(inp_ready),
                            int'(m_hdr || exp_q.size() == 0 || out_ready));
                checkOutput("busy", int'(busy), int'(!m_hdr));
                checkOutput("out_valid", int'(out_valid), int'(exp_q.size() != 0));
                if (out_valid && exp_q.size() != 0) begin
                    checkOutput("out_data", int'(out_data), exp_q[0].data);
                    checkOutput("out_sop", int'(out_sop), int'(exp_q[0].sop));
                    checkOutput("out_eop", int'(out_eop), int'(exp_q[0].eop));
                end
                if (out_valid && out_ready) begin
                    got.push_back('{int'(out_data), out_sop, out_eop});
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
                if (inp_valid && inp_ready) begin
                    if (m_hdr) begin
                        m_exp = int'(inp_data) % (2**EXP_W);
                        m_hdr = 0;
                        m_idx = 0;
                    end else begin
                        exp_q.push_back('{int'(inp_data) * (2**m_exp), m_idx == 0, m_idx == BLK - 1});
                        m_idx++;
                        if (m_idx == BLK) m_hdr = 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the word was accepted.
    task automatic applyStimulus(input logic [MAN_W-1:0] w);
        bit done;
        done = 0;
        inp_data  = w;
        inp_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (inp_ready) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("accept_timeout", 0, 1);
        inp_valid = 1'b0;
    endtask

    task automatic drainOutputs();
        bit done;
        done = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (!out_valid && exp_q.size() == 0) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("drain_timeout", 0, 1);
    endtask

    task automatic checkBlock(input string nm, input int v0, input int v1, input int v2, input int v3);
        int v[4];
        v = '{v0, v1, v2, v3};
        checkOutput({nm, "_count"}, got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                checkOutput({nm, "_data"}, got[i].data, v[i]);
                checkOutput({nm, "_sop"}, int'(got[i].sop), int'(i == 0));
                checkOutput({nm, "_eop"}, int'(got[i].eop), int'(i == 3));
            end
        end
    endtask

    task automatic sendBlock(input logic [MAN_W-1:0] h, input logic [MAN_W-1:0] a,
                             input logic [MAN_W-1:0] b, input logic [MAN_W-1:0] c,
                             input logic [MAN_W-1:0] d);
        applyStimulus(h);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(c);
        applyStimulus(d);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        inp_valid = 1'b0;
        inp_data  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_data", int'(out_data), 0);
        checkOutput("reset_sop_eop", int'({out_sop, out_eop}), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_inp_ready", int'(inp_ready), 1);
        @(posedge clk);
        #1;
        mon_en = 1;

        $display("[TB] basic decode");
        got.delete();
        sendBlock(5'd3, 5'd1, 5'd31, 5'd0, 5'd17);
        drainOutputs();
        checkBlock("basic", 8, 248, 0, 136);

        $display("[TB] extremes");
        got.delete();
        sendBlock(5'd7, 5'd31, 5'd0, 5'd0, 5'd0);
        drainOutputs();
        checkBlock("exp7", 'hF80, 0, 0, 0);
        got.delete();
        sendBlock(5'd0, 5'd31, 5'd0, 5'd1, 5'd2);
        drainOutputs();
        checkBlock("exp0", 31, 0, 1, 2);

        $display("[TB] header masking");
        got.delete();
        sendBlock(5'h1D, 5'd1, 5'd2, 5'd3, 5'd4);
        drainOutputs();
        checkBlock("mask", 32, 64, 96, 128);

        $display("[TB] backpressure");
        got.delete();
        applyStimulus(5'd3);
        out_ready = 1'b0;
        applyStimulus(5'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", int'(out_valid), 1);
            checkOutput("stall_data", int'(out_data), 8);
            checkOutput("stall_inp_ready", int'(inp_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(5'd31);
        applyStimulus(5'd0);
        applyStimulus(5'd17);
        out_ready = 1'b0;
        applyStimulus(5'd2);
        @(negedge clk);
        checkOutput("eop_stall_valid", int'(out_valid), 1);
        checkOutput("eop_stall_data", int'(out_data), 136);
        checkOutput("eop_stall_eop", int'(out_eop), 1);
        checkOutput("eop_stall_busy", int'(busy), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(5'd3);
        applyStimulus(5'd3);
        applyStimulus(5'd3);
        applyStimulus(5'd3);
        drainOutputs();
        checkOutput("bp_total", got.size(), 8);
        while (got.size() > 4) void'(got.pop_back());
        checkBlock("bp", 8, 248, 0, 136);

        $display("[TB] random back-to-back blocks");
        got.delete();
        rand_mode = 1;
        for (int b = 0; b < 15; b++) begin
            for (int w = 0; w <= BLK; w++) begin
                while ($urandom_range(0, 3) == 0) begin
                    inp_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
                applyStimulus(MAN_W'($urandom_range(0, 31)));
            end
        end
        rand_mode = 0;
        @(posedge clk);
        #1;
        drainOutputs();
        checkOutput("rand_count", got.size(), 15 * BLK);
        for (int i = 0; i < got.size(); i++) begin
            checkOutput("rand_sop", int'(got[i].sop), int'(i % BLK == 0));
            checkOutput("rand_eop", int'(got[i].eop), int'(i % BLK == BLK - 1));
        end

        $display("[TB] reset mid-block");
        got.delete();
        out_ready = 1'b1;
        applyStimulus(5'd3);
        applyStimulus(5'd1);
        applyStimulus(5'd2);
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("pre_reset_valid", int'(out_valid), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_valid", int'(out_valid), 0);
        checkOutput("post_reset_busy", int'(busy), 0);
        checkOutput("post_reset_data", int'(out_data), 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        got.delete();
        sendBlock(5'd2, 5'd1, 5'd5, 5'd6, 5'd7);
        drainOutputs();
        checkBlock("after_reset", 4, 20, 24, 28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bfp2fix_stream.md
Name: bfp2fix_stream

Overview:
- Streaming decoder for block-floating-point (shared-exponent) data. It is the receive-side counterpart of the shared-exponent encoder that pairs with fix2tfp.
- Each input block is one header word carrying the common exponent, followed by BLOCK_LEN mantissa words.
- Each mantissa is expanded to unsigned fixed-point with the same rule as tfp2fix: value = mantissa << exponent, zero-extended.
- Sits between the compressed-sample link and fixed-point DSP consumers. Input and output both use valid/ready handshakes.

Parameters:
- MAN_WIDTH, 5, mantissa width and input word width; must be >= EXP_WIDTH.
- EXP_WIDTH, 3, width of the shared exponent field.
- BLOCK_LEN, 4, mantissa words per block; must be >= 1.
- Derived, not overridable: FIX_WIDTH = MAN_WIDTH + 2**EXP_WIDTH - 1 (12 at defaults); CNT_WIDTH = max(1, $clog2(BLOCK_LEN)).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- inp_data  in  MAN_WIDTH  header or mantissa word.
- inp_valid  in  1  inp_data valid.
- inp_ready  out  1  block accepts inp_data this cycle.
- out_data  out  FIX_WIDTH  decoded fixed-point sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_sop  out  1  out_data is first sample of a block.
- out_eop  out  1  out_data is last sample of a block.
- busy  out  1  state is DATA, i.e. inside a block.

Behaviour:
- Transfers: an input transfer occurs when inp_valid & inp_ready; an output transfer occurs when out_valid & out_ready.
- Reset (synchronous, clk edge with rst=1):
  - state=HEADER, cnt=0, exp_reg=0.
  - out_valid=0, out_data=0, out_sop=0, out_eop=0, busy=0.
  - rst overrides all other activity. A block in progress is discarded and the output register is cleared, even if out_valid was high.
- State HEADER:
  - inp_ready=1 unconditionally.
  - On input transfer: exp_reg <= inp_data[EXP_WIDTH-1:0] (upper bits ignored), cnt <= 0, state <= DATA.
  - Headers produce no output.
  - The output register keeps holding and handshaking any pending last sample independently.
- State DATA:
  - inp_ready = ~out_valid | out_ready, a combinational path from out_ready.
  - On input transfer, registered, 1-cycle latency:
    - out_data <= zero_ext(inp_data) << exp_reg
    - out_valid <= 1
    - out_sop <= (cnt==0)
    - out_eop <= (cnt==BLOCK_LEN-1)
  - If cnt==BLOCK_LEN-1, state <= HEADER and cnt <= 0; otherwise cnt <= cnt+1.
- Output register:
  - If there is an output transfer and no new input transfer, out_valid <= 0.
  - out_data, out_sop and out_eop hold their values whenever out_valid=1 and out_ready=0.
- Width rule: shift range is 0..2**EXP_WIDTH-1, so the result always fits FIX_WIDTH with no overflow or truncation.
- Simultaneous events:
  - Output transfer and new mantissa in the same cycle: the new sample replaces the old with no bubble, so full throughput is 1 sample/cycle.
  - Header acceptance while the last sample of the previous block is still stalled is legal. It costs no output cycle.
  - Sustained rate: BLOCK_LEN samples per BLOCK_LEN+1 input words.
- BLOCK_LEN=1: every output has out_sop=1 and out_eop=1.
- busy=1 exactly while state==DATA.

Test Plan:
- Basic decode: defaults; header 3, mantissas 1,31,0,17, out_ready=1.
  - Outputs 8, 248, 0, 136, each one cycle after acceptance.
  - sop on the 8, eop on the 136.
  - inp_ready high throughout.
- Extremes: header 7 with mantissa 31 -> 0xF80; header 0 with mantissa 31 -> 31; header 0 with mantissa 0 -> 0.
- Header masking: header word 0x1D, then mantissas 1,2,3,4.
  - exp_reg=5 (upper bits ignored).
  - Outputs 32, 64, 96, 128.
- Backpressure: hold out_ready=0 for 3 cycles after the first sample.
  - out_data stays 8 with out_valid=1.
  - inp_ready=0 in DATA.
  - No sample is lost or duplicated.
  - Header accepted during a stall on the eop sample.
- Back-to-back blocks with random inp_valid/out_ready:
  - Output stream matches a reference model; sop/eop mark every 4th sample.
  - cnt and exp wrap correctly across blocks.
- Reset mid-block: assert rst after 2 mantissas while out_valid=1.
  - Next cycle out_valid=0, busy=0, out_data=0.
  - The following word is treated as a header.
